// File: rtl/profi_video_timing_if.sv
// Video timing bundle: colour inputs from the fetch/border logic, raster
// coordinates, and the registered sync/colour stream to the scandoubler.
interface profi_video_timing_if;
    logic       clk14en;
    logic [8:0] pixel_rgb;
    logic [8:0] border_rgb;
    logic [9:0] hcnt;
    logic [8:0] vcnt;
    logic       paper;
    logic [8:0] rgbi;
    logic       hsync_ext_n;
    logic       vsync_ext_n;
    logic       csync_ext_n;
    logic       blank;
    logic       int_n;

    modport master (
        input  clk14en, pixel_rgb, border_rgb,
        output hcnt, vcnt, paper, rgbi, hsync_ext_n, vsync_ext_n, csync_ext_n,
               blank, int_n
    );

    modport slave (
        output clk14en, pixel_rgb, border_rgb,
        input  hcnt, vcnt, paper, rgbi, hsync_ext_n, vsync_ext_n, csync_ext_n,
               blank, int_n
    );
endinterface

// File: rtl/profi_video_timing.sv
// 15 kHz raster timing generator: h/v counters, registered syncs, blanking,
// paper/border colour mux and the per-frame CPU interrupt.
module profi_video_timing #(
    parameter int unsigned H_TOTAL       = 896,
    parameter int unsigned H_ACTIVE      = 512,
    parameter int unsigned H_BLANK_START = 640,
    parameter int unsigned H_SYNC_START  = 704,
    parameter int unsigned H_SYNC_LEN    = 64,
    parameter int unsigned H_BLANK_END   = 832,
    parameter int unsigned V_TOTAL       = 320,
    parameter int unsigned V_ACTIVE      = 240,
    parameter int unsigned V_BLANK_START = 264,
    parameter int unsigned V_SYNC_START  = 272,
    parameter int unsigned V_SYNC_LEN    = 4,
    parameter int unsigned V_BLANK_END   = 296,
    parameter int unsigned INT_LEN       = 32
) (
    input logic                  clk,
    input logic                  reset,
    profi_video_timing_if.master vid
);
    localparam int unsigned HW = 10;
    localparam int unsigned VW = 9;
    localparam int unsigned CW = 9;
    localparam int unsigned IW = $clog2(INT_LEN + 1);

    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    logic [CW-1:0] rgbi_q;
    logic          hsync_n_q;
    logic          vsync_n_q;
    logic          csync_n_q;
    logic          blank_q;
    logic          int_n_q;
    logic [IW-1:0] int_cnt_q;

    logic h_last_c;
    logic v_last_c;
    logic hsync_c;
    logic vsync_c;
    logic hblank_c;
    logic vblank_c;
    logic paper_c;
    logic int_trig_c;

    // Region decode of the current counter value, registered on the next enable
    always_comb begin
        h_last_c   = (hcnt_q == HW'(H_TOTAL - 1));
        v_last_c   = (vcnt_q == VW'(V_TOTAL - 1));
        hsync_c    = (hcnt_q >= HW'(H_SYNC_START)) &&
                     (hcnt_q <  HW'(H_SYNC_START + H_SYNC_LEN));
        vsync_c    = (vcnt_q >= VW'(V_SYNC_START)) &&
                     (vcnt_q <  VW'(V_SYNC_START + V_SYNC_LEN));
        hblank_c   = (hcnt_q >= HW'(H_BLANK_START)) && (hcnt_q < HW'(H_BLANK_END));
        vblank_c   = (vcnt_q >= VW'(V_BLANK_START)) && (vcnt_q < VW'(V_BLANK_END));
        paper_c    = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
        int_trig_c = (hcnt_q == '0) && (vcnt_q == VW'(V_SYNC_START));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            rgbi_q    <= '0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            csync_n_q <= 1'b1;
            blank_q   <= 1'b1;
            int_n_q   <= 1'b1;
            int_cnt_q <= '0;
        end else if (vid.clk14en) begin
            hcnt_q <= h_last_c ? '0 : hcnt_q + HW'(1);
            if (h_last_c) begin
                vcnt_q <= v_last_c ? '0 : vcnt_q + VW'(1);
            end

            hsync_n_q <= ~hsync_c;
            vsync_n_q <= ~vsync_c;
            // Composite sync inverts during vsync lines (serrated)
            csync_n_q <= vsync_c ? hsync_c : ~hsync_c;
            blank_q   <= hblank_c | vblank_c;

            if (hblank_c || vblank_c) begin
                rgbi_q <= '0;
            end else if (paper_c) begin
                rgbi_q <= vid.pixel_rgb;
            end else begin
                rgbi_q <= vid.border_rgb;
            end

            // Interrupt stays low for INT_LEN enables; retrigger restarts the count
            if (int_trig_c) begin
                int_n_q   <= 1'b0;
                int_cnt_q <= IW'(INT_LEN - 1);
            end else if (int_cnt_q != '0) begin
                int_cnt_q <= int_cnt_q - IW'(1);
            end else begin
                int_n_q <= 1'b1;
            end
        end
    end

    assign vid.hcnt        = hcnt_q;
    assign vid.vcnt        = vcnt_q;
    assign vid.paper       = paper_c;
    assign vid.rgbi        = rgbi_q;
    assign vid.hsync_ext_n = hsync_n_q;
    assign vid.vsync_ext_n = vsync_n_q;
    assign vid.csync_ext_n = csync_n_q;
    assign vid.blank       = blank_q;
    assign vid.int_n       = int_n_q;
endmodule

// File: tb/tb_profi_video_timing.sv
// Bench for profi_video_timing: a scaled-down raster instance against a
// frame-arithmetic model, plus a default-geometry instance for line timing.
module tb_profi_video_timing;
    localparam int unsigned S_HT  = 64;
    localparam int unsigned S_HA  = 32;
    localparam int unsigned S_HBS = 40;
    localparam int unsigned S_HSS = 44;
    localparam int unsigned S_HSL = 6;
    localparam int unsigned S_HBE = 56;
    localparam int unsigned S_VT  = 40;
    localparam int unsigned S_VA  = 24;
    localparam int unsigned S_VBS = 28;
    localparam int unsigned S_VSS = 30;
    localparam int unsigned S_VSL = 3;
    localparam int unsigned S_VBE = 36;
    localparam int unsigned S_INT = 10;
    localparam int unsigned S_FR  = S_HT * S_VT;

    typedef struct {
        logic [9:0] hcnt;
        logic [8:0] vcnt;
        logic       paper;
        logic [8:0] rgbi;
        logic       hs;
        logic       vs;
        logic       cs;
        logic       blank;
        logic       int_n;
    } exp_t;

    typedef struct {
        int unsigned h;
        int unsigned v;
        logic [8:0]  pix;
        logic [8:0]  bor;
        logic        paper;
        logic [8:0]  rgbi;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        cs;
    } vec_t;

    logic clk;
    logic rst_s;
    logic rst_d;
    int   checks;
    int   errors;

    int unsigned n_s;
    logic [8:0]  lp_s;
    logic [8:0]  lb_s;

    profi_video_timing_if vs_if();
    profi_video_timing_if vd_if();

    profi_video_timing #(
        .H_TOTAL(S_HT), .H_ACTIVE(S_HA), .H_BLANK_START(S_HBS),
        .H_SYNC_START(S_HSS), .H_SYNC_LEN(S_HSL), .H_BLANK_END(S_HBE),
        .V_TOTAL(S_VT), .V_ACTIVE(S_VA), .V_BLANK_START(S_VBS),
        .V_SYNC_START(S_VSS), .V_SYNC_LEN(S_VSL), .V_BLANK_END(S_VBE),
        .INT_LEN(S_INT)
    ) dut_s (
        .clk(clk), .reset(rst_s), .vid(vs_if)
    );

    profi_video_timing dut_d (
        .clk(clk), .reset(rst_d), .vid(vd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected outputs after n enables since reset, from raster arithmetic
    function automatic exp_t model(input int unsigned n, input logic [8:0] lp,
                                   input logic [8:0] lb);
        exp_t e;
        int unsigned p, ph, pv, tr;
        logic hs, vs, bl, pp;
        e.hcnt  = 10'(n % S_HT);
        e.vcnt  = 9'((n / S_HT) % S_VT);
        e.paper = ((n % S_HT) < S_HA) && (((n / S_HT) % S_VT) < S_VA);
        if (n == 0) begin
            e.rgbi = '0; e.hs = 1'b1; e.vs = 1'b1; e.cs = 1'b1;
            e.blank = 1'b1; e.int_n = 1'b1;
        end else begin
            p  = n - 1;
            ph = p % S_HT;
            pv = (p / S_HT) % S_VT;
            hs = (ph >= S_HSS) && (ph < S_HSS + S_HSL);
            vs = (pv >= S_VSS) && (pv < S_VSS + S_VSL);
            bl = ((ph >= S_HBS) && (ph < S_HBE)) || ((pv >= S_VBS) && (pv < S_VBE));
            pp = (ph < S_HA) && (pv < S_VA);
            e.rgbi  = bl ? 9'h000 : (pp ? lp : lb);
            e.hs    = !hs;
            e.vs    = !vs;
            e.cs    = vs ? hs : !hs;
            e.blank = bl;
            tr      = S_VSS * S_HT;
            e.int_n = !((p >= tr) && (((p - tr) % S_FR) < S_INT));
        end
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, " hcnt"},  32'(vs_if.hcnt),        32'(e.hcnt));
        chk({tag, " vcnt"},  32'(vs_if.vcnt),        32'(e.vcnt));
        chk({tag, " paper"}, 32'(vs_if.paper),       32'(e.paper));
        chk({tag, " rgbi"},  32'(vs_if.rgbi),        32'(e.rgbi));
        chk({tag, " hs"},    32'(vs_if.hsync_ext_n), 32'(e.hs));
        chk({tag, " vs"},    32'(vs_if.vsync_ext_n), 32'(e.vs));
        chk({tag, " cs"},    32'(vs_if.csync_ext_n), 32'(e.cs));
        chk({tag, " blank"}, 32'(vs_if.blank),       32'(e.blank));
        chk({tag, " int_n"}, 32'(vs_if.int_n),       32'(e.int_n));
    endtask

    // One clk on the small instance; called and returns at a falling edge
    task automatic tick_s(input logic en, input logic [8:0] pix, input logic [8:0] bor,
                          input logic r);
        vs_if.clk14en    = en;
        vs_if.pixel_rgb  = pix;
        vs_if.border_rgb = bor;
        rst_s            = r;
        @(posedge clk);
        if (r) begin
            n_s = 0;
        end else if (en) begin
            n_s++;
            lp_s = pix;
            lb_s = bor;
        end
        @(negedge clk);
    endtask

    vec_t tbl[18];

    initial begin
        int unsigned ens, c, first_ens, first_c, second_c, falls, k;
        int unsigned hs_low, vs_low, int_low, int_falls;
        logic prev_hs, prev_int, en, fell;

        checks = 0; errors = 0;
        n_s = 0; lp_s = '0; lb_s = '0;
        rst_s = 1'b1; rst_d = 1'b1;
        vs_if.clk14en = 1'b0; vs_if.pixel_rgb = '0; vs_if.border_rgb = '0;
        vd_if.clk14en = 1'b0; vd_if.pixel_rgb = 9'h1FF; vd_if.border_rgb = 9'h049;

        tbl[0]  = '{0,  0,  9'h1FF, 9'h049, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{31, 0,  9'h1FF, 9'h049, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{32, 0,  9'h1FF, 9'h049, 1'b0, 9'h049, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{44, 5,  9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{49, 5,  9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{50, 5,  9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{56, 5,  9'h1FF, 9'h049, 1'b0, 9'h049, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{20, 10, 9'h0AA, 9'h155, 1'b1, 9'h0AA, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{31, 23, 9'h1FF, 9'h049, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{39, 23, 9'h1FF, 9'h049, 1'b0, 9'h049, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{40, 23, 9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{63, 24, 9'h1FF, 9'h123, 1'b0, 9'h123, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{10, 28, 9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{10, 30, 9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{45, 31, 9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{5,  33, 9'h1FF, 9'h049, 1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{5,  36, 9'h1FF, 9'h049, 1'b0, 9'h049, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[17] = '{31, 39, 9'h1FF, 9'h049, 1'b0, 9'h049, 1'b0, 1'b1, 1'b1, 1'b1};

        @(negedge clk);

        // Default geometry: reset values, then enable every 2nd clk
        @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        chk("dflt rst hcnt",  32'(vd_if.hcnt),        32'd0);
        chk("dflt rst vcnt",  32'(vd_if.vcnt),        32'd0);
        chk("dflt rst rgbi",  32'(vd_if.rgbi),        32'd0);
        chk("dflt rst hs",    32'(vd_if.hsync_ext_n), 32'd1);
        chk("dflt rst vs",    32'(vd_if.vsync_ext_n), 32'd1);
        chk("dflt rst cs",    32'(vd_if.csync_ext_n), 32'd1);
        chk("dflt rst blank", 32'(vd_if.blank),       32'd1);
        chk("dflt rst int_n", 32'(vd_if.int_n),       32'd1);
        ens = 0; c = 0; falls = 0; first_ens = 0; first_c = 0; second_c = 0;
        prev_hs = 1'b1;
        while (falls < 2 && c < 6000) begin
            en = (c % 2 == 0);
            vd_if.clk14en = en;
            @(posedge clk);
            if (en) ens++;
            @(negedge clk);
            chk("dflt hcnt", 32'(vd_if.hcnt), ens % 896);
            chk("dflt vcnt", 32'(vd_if.vcnt), ens / 896);
            if (prev_hs && !vd_if.hsync_ext_n) begin
                if (falls == 0) begin
                    first_ens = ens;
                    first_c   = c;
                end else begin
                    second_c = c;
                end
                falls++;
            end
            prev_hs = vd_if.hsync_ext_n;
            c++;
        end
        vd_if.clk14en = 1'b0;
        chk("dflt hs falls seen",      falls, 2);
        chk("dflt first hs fall ens",  first_ens, 705);
        chk("dflt hs period clk",      second_c - first_c, 1792);

        // Table vectors on the small instance, walking one frame from reset
        tick_s(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            while (n_s < tbl[i].v * S_HT + tbl[i].h)
                tick_s(1'b1, 9'($urandom), 9'($urandom), 1'b0);
            chk($sformatf("tbl%0d paper", i), 32'(vs_if.paper), 32'(tbl[i].paper));
            tick_s(1'b1, tbl[i].pix, tbl[i].bor, 1'b0);
            chk($sformatf("tbl%0d rgbi", i),  32'(vs_if.rgbi),        32'(tbl[i].rgbi));
            chk($sformatf("tbl%0d blank", i), 32'(vs_if.blank),       32'(tbl[i].blank));
            chk($sformatf("tbl%0d hs", i),    32'(vs_if.hsync_ext_n), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d vs", i),    32'(vs_if.vsync_ext_n), 32'(tbl[i].vs));
            chk($sformatf("tbl%0d cs", i),    32'(vs_if.csync_ext_n), 32'(tbl[i].cs));
        end

        // Mid-frame reset with the enable also high
        tick_s(1'b0, '0, '0, 1'b1);
        while (n_s < 10 * S_HT + 20) tick_s(1'b1, 9'h1FF, 9'h049, 1'b0);
        chk("pre-rst hcnt", 32'(vs_if.hcnt), 32'd20);
        chk("pre-rst vcnt", 32'(vs_if.vcnt), 32'd10);
        tick_s(1'b1, 9'h1FF, 9'h049, 1'b1);
        chk("mid rst hcnt",  32'(vs_if.hcnt),        32'd0);
        chk("mid rst vcnt",  32'(vs_if.vcnt),        32'd0);
        chk("mid rst rgbi",  32'(vs_if.rgbi),        32'd0);
        chk("mid rst hs",    32'(vs_if.hsync_ext_n), 32'd1);
        chk("mid rst vs",    32'(vs_if.vsync_ext_n), 32'd1);
        chk("mid rst cs",    32'(vs_if.csync_ext_n), 32'd1);
        chk("mid rst blank", 32'(vs_if.blank),       32'd1);
        chk("mid rst int_n", 32'(vs_if.int_n),       32'd1);
        k = 0; fell = 1'b0;
        while (!fell && k < 200) begin
            tick_s(1'b1, 9'h1FF, 9'h049, 1'b0);
            k++;
            if (!vs_if.hsync_ext_n) fell = 1'b1;
        end
        chk("mid rst first hs fall", k, S_HSS + 1);

        // One full frame from reset: edge and window counts
        tick_s(1'b0, '0, '0, 1'b1);
        hs_low = 0; vs_low = 0; int_low = 0; int_falls = 0; falls = 0;
        prev_hs = 1'b1; prev_int = 1'b1;
        for (int i = 0; i < int'(S_FR); i++) begin
            tick_s(1'b1, 9'($urandom), 9'($urandom), 1'b0);
            if (prev_hs && !vs_if.hsync_ext_n) falls++;
            if (prev_int && !vs_if.int_n) int_falls++;
            if (!vs_if.hsync_ext_n) hs_low++;
            if (!vs_if.vsync_ext_n) vs_low++;
            if (!vs_if.int_n) int_low++;
            prev_hs  = vs_if.hsync_ext_n;
            prev_int = vs_if.int_n;
        end
        chk("frame hs falls",   falls,     S_VT);
        chk("frame hs low",     hs_low,    S_VT * S_HSL);
        chk("frame vs low",     vs_low,    S_VSL * S_HT);
        chk("frame int falls",  int_falls, 1);
        chk("frame int low",    int_low,   S_INT);
        chk("frame end hcnt",   32'(vs_if.hcnt), 32'd0);
        chk("frame end vcnt",   32'(vs_if.vcnt), 32'd0);

        // Random enables, colours and occasional resets against the model
        tick_s(1'b1, 9'($urandom), 9'($urandom), 1'b1);
        compare_all("rnd reset", model(n_s, lp_s, lb_s));
        for (int i = 0; i < 6000; i++) begin
            tick_s($urandom_range(0, 3) != 0, 9'($urandom), 9'($urandom),
                   $urandom_range(0, 1999) == 0);
            compare_all("rnd", model(n_s, lp_s, lb_s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
